msdf_to_binary: RTL and testbench

MSDF_TO_BINARY -- requirements
Module: msdf_to_binary

---
 rtl/msdf_to_binary.sv | 129 ++++++++++++
 tb/tb_msdf_to_binary.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/msdf_to_binary.sv
// msdf_to_binary: on-the-fly conversion of an MSD-first signed-digit stream into a two's-complement word.
// Optional macro MSDF_CONV_READY_BYPASS_EN lets the next word start in the same cycle that a result is taken.
module msdf_to_binary #(
  parameter int TARGET_PRECISION = 25,
  parameter int OUT_WIDTH        = TARGET_PRECISION + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           dataInArray_0,
  input  logic                 pValidArray_0,
  output logic                 readyArray_0,
  output logic [OUT_WIDTH-1:0] dataOutArray_0,
  output logic                 validArray_0,
  input  logic                 nReadyArray_0
);

  localparam int CW = (TARGET_PRECISION > 1) ? $clog2(TARGET_PRECISION) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(TARGET_PRECISION - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t               stateReg;
  logic [CW-1:0]        countReg;
  logic                 validReg;
  logic [OUT_WIDTH-1:0] qReg;
  logic [OUT_WIDTH-1:0] qmReg;
  logic [OUT_WIDTH-1:0] baseQ;
  logic [OUT_WIDTH-1:0] baseQm;
  logic [OUT_WIDTH-1:0] qNext;
  logic [OUT_WIDTH-1:0] qmNext;
  logic                 digitPos;
  logic                 digitNeg;
  logic                 unusedDigitBit;

  // Encoding 2'b11 (and 2'b00) both decode to zero.
  assign digitPos       = dataInArray_0[1] & ~dataInArray_0[0];
  assign digitNeg       = ~dataInArray_0[1] & dataInArray_0[0];
  assign unusedDigitBit = dataInArray_0[2];

  // A digit taken while in HOLD can only be the first digit of a fresh word.
  always_comb begin
    baseQ  = qReg;
    baseQm = qmReg;
    qNext  = '0;
    qmNext = '1;
    if (stateReg == HOLD) begin
      baseQ  = '0;
      baseQm = '1;
    end
    if (digitPos) begin
      qNext  = {baseQ[OUT_WIDTH-2:0], 1'b1};
      qmNext = {baseQ[OUT_WIDTH-2:0], 1'b0};
    end else if (digitNeg) begin
      qNext  = {baseQm[OUT_WIDTH-2:0], 1'b1};
      qmNext = {baseQm[OUT_WIDTH-2:0], 1'b0};
    end else begin
      qNext  = {baseQ[OUT_WIDTH-2:0], 1'b0};
      qmNext = {baseQm[OUT_WIDTH-2:0], 1'b1};
    end
  end

`ifdef MSDF_CONV_READY_BYPASS_EN
  assign readyArray_0 = (stateReg == COLLECT) | nReadyArray_0;
`else
  assign readyArray_0 = (stateReg == COLLECT);
`endif

  assign dataOutArray_0 = qReg;
  assign validArray_0   = validReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= COLLECT;
      countReg <= '0;
      validReg <= 1'b0;
      qReg     <= '0;
      qmReg    <= '1;
    end else begin
      case (stateReg)
        COLLECT: begin
          if (pValidArray_0) begin
            qReg  <= qNext;
            qmReg <= qmNext;
            if (countReg == LAST_DIGIT) begin
              stateReg <= HOLD;
              validReg <= 1'b1;
              countReg <= '0;
            end else begin
              countReg <= countReg + 1'b1;
            end
          end
        end
        HOLD: begin
          if (nReadyArray_0) begin
`ifdef MSDF_CONV_READY_BYPASS_EN
            if (pValidArray_0) begin
              qReg  <= qNext;
              qmReg <= qmNext;
              if (TARGET_PRECISION == 1) begin
                stateReg <= HOLD;
                validReg <= 1'b1;
                countReg <= '0;
              end else begin
                stateReg <= COLLECT;
                validReg <= 1'b0;
                countReg <= CW'(1);
              end
            end else begin
              stateReg <= COLLECT;
              validReg <= 1'b0;
              countReg <= '0;
              qReg     <= '0;
              qmReg    <= '1;
            end
`else
            stateReg <= COLLECT;
            validReg <= 1'b0;
            countReg <= '0;
            qReg     <= '0;
            qmReg    <= '1;
`endif
          end
        end
        default: stateReg <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_msdf_to_binary.sv
// Self-checking bench for msdf_to_binary (N=4): directed words, stalls, resets and random words
// checked against an arithmetic reference (sum of d_i * 2^(N-i)).
module tb_msdf_to_binary;

  localparam int N = 4;
  localparam int W = N + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   dataIn = '0;
  logic         pValid = 1'b0;
  logic         ready;
  logic [W-1:0] dataOut;
  logic         valid;
  logic         nReady = 1'b1;

  int total = 0;
  int bad   = 0;

  msdf_to_binary #(.TARGET_PRECISION(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .dataInArray_0  (dataIn),
    .pValidArray_0  (pValid),
    .readyArray_0   (ready),
    .dataOutArray_0 (dataOut),
    .validArray_0   (valid),
    .nReadyArray_0  (nReady)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference value of an MSD-first digit word, straight from the digit weights.
  function automatic logic [W-1:0] refValue(input logic [3*N-1:0] encs);
    int acc;
    logic [2:0] e;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      e = encs[3*N-1-3*i -: 3];
      acc += (int'(e[1]) - int'(e[0])) * (1 << (N-1-i));
    end
    return W'(acc);
  endfunction

  // Offers N digits starting at a negedge; returns at the negedge after the N-th acceptance.
  task automatic sendDigits(input logic [3*N-1:0] encs, input bit gaps, input string tag);
    int t;
    for (int i = 0; i < N; i++) begin
      if (gaps && i > 0) begin
        pValid = 1'b0;
        dataIn = 3'($urandom);
        step();
      end
      pValid = 1'b1;
      dataIn = encs[3*N-1-3*i -: 3];
      t = 0;
      while (ready !== 1'b1 && t < 10) begin
        step();
        t++;
      end
      if (t >= 10) chk({tag, "_readyTimeout"}, 32'(ready), 32'd1);
      step();
    end
    pValid = 1'b0;
    dataIn = 3'($urandom);
  endtask

  // Checks a completed word held for `stall` cycles, then its single-cycle transfer.
  task automatic checkResult(input logic [W-1:0] expv, input int stall, input string tag);
    for (int k = 0; k < stall; k++) begin
      chk({tag, "_holdValid"}, 32'(valid), 32'd1);
      chk({tag, "_holdData"}, 32'(dataOut), 32'(expv));
`ifdef MSDF_CONV_READY_BYPASS_EN
      chk({tag, "_holdReady"}, 32'(ready), 32'(nReady));
`else
      chk({tag, "_holdReady"}, 32'(ready), 32'd0);
`endif
      step();
    end
    nReady = 1'b1;
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_data"}, 32'(dataOut), 32'(expv));
    $display("word %s: result=%b expected=%b", tag, dataOut, expv);
    step();
    chk({tag, "_validDrop"}, 32'(valid), 32'd0);
  endtask

  task automatic runWord(input logic [3*N-1:0] encs, input bit gaps, input int stall, input string tag);
    nReady = (stall == 0);
    sendDigits(encs, gaps, tag);
    checkResult(refValue(encs), stall, tag);
  endtask

  initial begin
    logic [3*N-1:0] encs;
    logic [2:0]     stream [3*N];
    logic [W-1:0]   expv;

    step();
    step();
    chk("rstValid", 32'(valid), 32'd0);
    chk("rstData", 32'(dataOut), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstReady", 32'(ready), 32'd1);
    step();

    // Directed words: +1,0,-1,+1 / all -1 / all +1
    runWord({3'b010, 3'b000, 3'b001, 3'b010}, 1'b0, 0, "mixed");
    chk("mixedConst", 32'(refValue({3'b010, 3'b000, 3'b001, 3'b010})), 32'h07);
    runWord({3'b001, 3'b001, 3'b001, 3'b001}, 1'b0, 0, "allNeg");
    chk("allNegConst", 32'(refValue({3'b001, 3'b001, 3'b001, 3'b001})), 32'h11);
    runWord({3'b010, 3'b010, 3'b010, 3'b010}, 1'b0, 0, "allPos");

    // Stalled transfer, then 2'b11 encoding with and without gaps
    runWord({3'b110, 3'b010, 3'b001, 3'b010}, 1'b0, 3, "stall3");
    runWord({3'b011, 3'b010, 3'b000, 3'b001}, 1'b0, 0, "enc11");
    runWord({3'b111, 3'b110, 3'b100, 3'b101}, 1'b1, 0, "enc11Gaps");

    // Reset mid-word discards the partial digits
    nReady = 1'b1;
    pValid = 1'b1;
    dataIn = 3'b010;
    step();
    dataIn = 3'b001;
    step();
    pValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midRstValid", 32'(valid), 32'd0);
    chk("midRstData", 32'(dataOut), 32'd0);
    step();
    chk("midRstValid2", 32'(valid), 32'd0);
    rst = 1'b0;
    runWord({3'b010, 3'b010, 3'b010, 3'b010}, 1'b0, 0, "afterMidRst");

    // Reset while holding a result drops it asynchronously
    nReady = 1'b0;
    sendDigits({3'b010, 3'b001, 3'b010, 3'b010}, 1'b0, "holdRst");
    chk("holdRstPreValid", 32'(valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("holdRstValid", 32'(valid), 32'd0);
    chk("holdRstData", 32'(dataOut), 32'd0);
    step();
    rst = 1'b0;
    nReady = 1'b1;
    #1;
    chk("holdRstReady", 32'(ready), 32'd1);
    step();
    runWord({3'b001, 3'b000, 3'b000, 3'b010}, 1'b0, 0, "afterHoldRst");

    // Random words with random gaps and stalls
    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < N; i++) encs[3*i +: 3] = 3'($urandom);
      runWord(encs, 1'($urandom), int'($urandom_range(0, 3)), $sformatf("rand%0d", w));
    end

`ifdef MSDF_CONV_READY_BYPASS_EN
    // Continuous stream: one result every N cycles
    for (int k = 0; k < 3*N; k++) stream[k] = 3'($urandom);
    nReady = 1'b1;
    pValid = 1'b1;
    for (int p = 1; p <= 3*N; p++) begin
      dataIn = stream[p-1];
      step();
      chk($sformatf("streamValid%0d", p), 32'(valid), 32'((p % N) == 0));
      if ((p % N) == 0) begin
        for (int i = 0; i < N; i++) encs[3*N-1-3*i -: 3] = stream[p-N+i];
        expv = refValue(encs);
        chk($sformatf("streamData%0d", p), 32'(dataOut), 32'(expv));
        $display("word stream%0d: result=%b expected=%b", p / N, dataOut, expv);
      end
    end
    pValid = 1'b0;
    step();
`else
    stream[0] = 3'b000;
    expv = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
